// File: rtl/instruction_fetch_unit_pkg.sv
// Shared JZJCoreF fetch-stage types and constants.
// The HALT state exists only when JZJCOREF_FETCH_MISALIGN_TRAP_EN is defined.
package JZJCoreFTypes;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h00000013;

`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, WAIT_DISCARD, PRESENT, HALT} FetchState_t;
`else
  typedef enum logic [1:0] {FETCH, WAIT_DISCARD, PRESENT} FetchState_t;
`endif

endpackage

// File: rtl/instruction_fetch_unit_fetch_program_counter.sv
// Program counter: redirect load, +4 increment, alignment masking.
// Low target bits are kept only when JZJCOREF_FETCH_MISALIGN_TRAP_EN is defined.
module fetch_program_counter
  import JZJCoreFTypes::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            increment,
  input  logic [XLEN-1:0] redirectAddress,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] target;

`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
  assign target = redirectAddress;
`else
  assign target = redirectAddress & ~XLEN'(3);
`endif

  // Redirect wins over increment; increment wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= target;
    end else if (increment) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// JZJCoreF fetch stage: owns the PC, fetches over req/valid, presents over valid/accept.
// Optional misaligned-redirect trap: JZJCOREF_FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit
  import JZJCoreFTypes::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            fetchRequest,
  output logic [XLEN-1:0] fetchAddress,
  input  logic            fetchValid,
  input  logic [XLEN-1:0] fetchData,
  output logic            instructionValid,
  input  logic            instructionAccept,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pcOfInstruction,
  output logic [XLEN-1:0] immediateU,
  input  logic            pcRedirect,
  input  logic [XLEN-1:0] redirectAddress
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalignedFault
`endif
);

  FetchState_t     state;
  FetchState_t     redirectState;
  FetchState_t     drainState;
  logic [XLEN-1:0] staleAddr;
  logic [XLEN-1:0] pc;
  logic            pcLoad;
  logic            pcIncrement;

  fetch_program_counter #(.RESET_VECTOR(RESET_VECTOR)) programCounter (
    .clock          (clock),
    .reset          (reset),
    .load           (pcLoad),
    .increment      (pcIncrement),
    .redirectAddress(redirectAddress),
    .pc             (pc)
  );

`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
  logic trapNow;
  logic haltPending;

  assign trapNow = pcRedirect && (redirectAddress[1:0] != 2'b00) && (state != HALT);

  // Fault is sticky until reset; haltPending remembers a trap seen while draining.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misalignedFault <= 1'b0;
      haltPending     <= 1'b0;
    end else if (trapNow) begin
      misalignedFault <= 1'b1;
      haltPending     <= 1'b1;
    end
  end
`endif

  // Memory-side outputs and PC strobes; the request drops as soon as reset asserts.
  always_comb begin
    fetchRequest  = reset && ((state == FETCH) || (state == WAIT_DISCARD));
    fetchAddress  = (state == WAIT_DISCARD) ? staleAddr : pc;
    pcLoad        = pcRedirect;
    pcIncrement   = (state == PRESENT) && instructionAccept && !pcRedirect;
    redirectState = FETCH;
    drainState    = FETCH;
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    if (trapNow) redirectState = HALT;
    if (trapNow || haltPending) drainState = HALT;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= FETCH;
      staleAddr        <= RESET_VECTOR;
      instructionValid <= 1'b0;
      instruction      <= NOP_INSTRUCTION;
      immediateU       <= '0;
      pcOfInstruction  <= RESET_VECTOR;
    end else begin
      case (state)
        FETCH: begin
          if (pcRedirect) begin
            if (fetchValid) begin
              state <= redirectState;
            end else begin
              // Keep the address stable under the live request until it drains.
              staleAddr <= pc;
              state     <= WAIT_DISCARD;
            end
          end else if (fetchValid) begin
            instruction      <= fetchData;
            immediateU       <= {fetchData[31:12], 12'b0};
            pcOfInstruction  <= pc;
            instructionValid <= 1'b1;
            state            <= PRESENT;
          end
        end
        WAIT_DISCARD: begin
          if (fetchValid) state <= drainState;
        end
        PRESENT: begin
          if (pcRedirect) begin
            instructionValid <= 1'b0;
            state            <= redirectState;
          end else if (instructionAccept) begin
            instructionValid <= 1'b0;
            state            <= FETCH;
          end
        end
        default: begin
          instructionValid <= 1'b0;
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
          state <= HALT;
`else
          state <= FETCH;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit; memory model answers after memLatency wait cycles.
// Exercises the trap path when JZJCOREF_FETCH_MISALIGN_TRAP_EN is defined.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchValid = 1'b0;
  logic [31:0] fetchData = 32'h0;
  logic        instructionValid;
  logic        instructionAccept = 1'b1;
  logic [31:0] instruction;
  logic [31:0] pcOfInstruction;
  logic [31:0] immediateU;
  logic        pcRedirect = 1'b0;
  logic [31:0] redirectAddress = 32'h0;
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
  logic        misalignedFault;
`endif

  int checks = 0;
  int passes = 0;
  int memLatency = 0;
  int waitCnt = 0;
  logic validPrev = 1'b0;
  expect_t expectQ[$];

  instruction_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .fetchRequest     (fetchRequest),
    .fetchAddress     (fetchAddress),
    .fetchValid       (fetchValid),
    .fetchData        (fetchData),
    .instructionValid (instructionValid),
    .instructionAccept(instructionAccept),
    .instruction      (instruction),
    .pcOfInstruction  (pcOfInstruction),
    .immediateU       (immediateU),
    .pcRedirect       (pcRedirect),
    .redirectAddress  (redirectAddress)
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    ,
    .misalignedFault  (misalignedFault)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h12345037;
    return {addr[19:0], 12'h037};
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm);
    expect_t e;
    e.pc = pc; e.instr = instr; e.imm = imm;
    expectQ.push_back(e);
  endtask

  // Memory responder: valid after memLatency wait cycles of a live request.
  always @(negedge clock) begin
    if (fetchRequest) begin
      if (waitCnt >= memLatency) begin
        fetchValid = 1'b1;
        fetchData  = memWord(fetchAddress);
        waitCnt    = 0;
      end else begin
        fetchValid = 1'b0;
        waitCnt++;
      end
    end else begin
      fetchValid = 1'b0;
      waitCnt    = 0;
    end
  end

  // Monitor: every new presentation must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      validPrev = 1'b0;
    end else begin
      if (instructionValid && !validPrev) begin
        if (expectQ.size() == 0) begin
          check("unexpected presentation pc", pcOfInstruction, 32'hxxxxxxxx);
        end else begin
          expect_t e;
          e = expectQ.pop_front();
          check("present pc", pcOfInstruction, e.pc);
          check("present instruction", instruction, e.instr);
          check("present immediateU", immediateU, e.imm);
        end
      end
      validPrev = instructionValid;
    end
  end

  task automatic nextFetch();
    int i;
    i = 0;
    @(negedge clock);
    while (!fetchRequest && i < 8) begin
      @(negedge clock);
      i++;
    end
    check("fetch request timeout", 32'(fetchRequest), 32'd1);
  endtask

  task automatic waitValid();
    for (int i = 0; i < 16 && !instructionValid; i++) @(negedge clock);
    check("present timeout", 32'(instructionValid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic stableOk;
    int   staleCnt;

    // Reset values
    repeat (2) @(negedge clock);
    check("reset fetchRequest", 32'(fetchRequest), 32'd0);
    check("reset instructionValid", 32'(instructionValid), 32'd0);
    check("reset instruction", instruction, 32'h00000013);
    check("reset immediateU", immediateU, 32'h0);
    check("reset pcOfInstruction", pcOfInstruction, 32'h0);
    check("reset fetchAddress", fetchAddress, 32'h0);
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    check("reset misalignedFault", 32'(misalignedFault), 32'd0);
`endif

    // Zero-wait streaming 0,4,8,C then 0x10
    for (int k = 0; k < 4; k++) push(32'(4 * k), {12'h0, 8'(4 * k), 12'h037}, {12'h0, 8'(4 * k), 12'h000});
    push(32'h10, 32'h12345037, 32'h12345000);
    push(32'h14, 32'h00014037, 32'h00014000);
    @(posedge clock); #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nextFetch();
      check("stream fetchAddress", fetchAddress, 32'(4 * k));
      @(negedge clock);
      check("stream present valid", 32'(instructionValid), 32'd1);
      check("stream present no request", 32'(fetchRequest), 32'd0);
    end
    nextFetch();
    check("fetchAddress 0x10", fetchAddress, 32'h10);
    instructionAccept = 1'b0;

    // Stall in PRESENT for 5 cycles
    @(negedge clock);
    stableOk = 1'b1;
    repeat (5) begin
      @(negedge clock);
      stableOk &= (instruction == 32'h12345037) && (immediateU == 32'h12345000) &&
                  instructionValid && !fetchRequest && (fetchAddress == 32'h10) &&
                  (pcOfInstruction == 32'h10);
    end
    check("stall outputs stable", 32'(stableOk), 32'd1);
    instructionAccept = 1'b1;
    nextFetch();
    check("after stall fetchAddress", fetchAddress, 32'h14);
    instructionAccept = 1'b0;
    @(negedge clock);

    // 3-cycle memory, redirect on first wait cycle
    memLatency = 3;
    push(32'h200, 32'h00200037, 32'h00200000);
    instructionAccept = 1'b1;
    @(negedge clock);
    check("slow fetchAddress", fetchAddress, 32'h18);
    pcRedirect = 1'b1;
    redirectAddress = 32'h200;
    @(negedge clock);
    pcRedirect = 1'b0;
    staleCnt = 0;
    for (int i = 0; i < 12 && fetchAddress != 32'h200; i++) begin
      if (fetchAddress == 32'h18 && fetchRequest) staleCnt++;
      @(negedge clock);
    end
    check("redirect target fetchAddress", fetchAddress, 32'h200);
    check("stale address hold cycles", 32'(staleCnt), 32'd3);
    instructionAccept = 1'b0;
    waitValid();

    // Redirect beats accept, then wrap past 0xFFFFFFFC
    memLatency = 0;
    push(32'hFFFFFFFC, 32'hFFFFC037, 32'hFFFFC000);
    push(32'h0, 32'h00000037, 32'h0);
    pcRedirect = 1'b1;
    redirectAddress = 32'hFFFFFFFC;
    instructionAccept = 1'b1;
    @(negedge clock);
    pcRedirect = 1'b0;
    check("valid falls after redirect", 32'(instructionValid), 32'd0);
    check("redirect fetchAddress", fetchAddress, 32'hFFFFFFFC);
    @(negedge clock);
    check("top-of-memory present", 32'(instructionValid), 32'd1);
    @(negedge clock);
    check("valid falls after accept", 32'(instructionValid), 32'd0);
    check("wrap fetchAddress", fetchAddress, 32'h0);
    instructionAccept = 1'b0;
    waitValid();

    // Misaligned redirect to 0x102
    pcRedirect = 1'b1;
    redirectAddress = 32'h102;
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    @(negedge clock);
    pcRedirect = 1'b0;
    check("misalignedFault set", 32'(misalignedFault), 32'd1);
    check("halt instructionValid", 32'(instructionValid), 32'd0);
    stableOk = !fetchRequest;
    repeat (3) begin
      @(negedge clock);
      stableOk &= !fetchRequest && !instructionValid;
    end
    check("halt no requests", 32'(stableOk), 32'd1);
    @(posedge clock); #2 reset = 1'b0;
    #1;
    check("fault cleared by reset", 32'(misalignedFault), 32'd0);
    check("reset vector fetchAddress", fetchAddress, 32'h0);
`else
    push(32'h100, 32'h00100037, 32'h00100000);
    @(negedge clock);
    pcRedirect = 1'b0;
    check("masked redirect fetchAddress", fetchAddress, 32'h100);
    waitValid();
    @(posedge clock); #2 reset = 1'b0;
    #1;
    check("mid reset instructionValid", 32'(instructionValid), 32'd0);
    check("mid reset instruction", instruction, 32'h00000013);
    check("mid reset pcOfInstruction", pcOfInstruction, 32'h0);
    check("mid reset fetchAddress", fetchAddress, 32'h0);
`endif
    check("reset fetchRequest low", 32'(fetchRequest), 32'd0);
    push(32'h0, 32'h00000037, 32'h0);
    @(posedge clock); #2 reset = 1'b1;
    waitValid();
    repeat (2) @(negedge clock);
    check("scoreboard drained", 32'(expectQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
